// File: rtl/piano_pkg.sv
// Shared constants for the piano front end: button channel map and default
// event-queue depth.
package piano_pkg;

  localparam int NUM_BTN = 5;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

  localparam int FIFO_DEPTH = 4;

  // Pointer wrap relies on plain binary overflow, so depths must be 2^n, n >= 1.
  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through synchronous FIFO: head shows the oldest entry
// combinationally while count is non-zero.
module event_fifo
  import piano_pkg::*;
#(
  parameter  int WIDTH = 3,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A pop frees the slot the same cycle, so push into a full queue is fine then.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; entries are only ever read behind a valid
  // count, and leaving it out lets the array map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/button_event_scheduler.sv
// Latches one-cycle button pulses, serialises them by fixed priority
// (C first, D last) into an FWFT event queue, and flags lost presses.
module button_event_scheduler
  import piano_pkg::*;
#(
  parameter  int NUM_BTN    = piano_pkg::NUM_BTN,
  parameter  int FIFO_DEPTH = piano_pkg::FIFO_DEPTH,
  localparam int ID_W       = $clog2(NUM_BTN),
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_pulse,
  output logic               evt_valid,
  output logic [ID_W-1:0]    evt_id,
  input  logic               evt_ready,
  output logic [NUM_BTN-1:0] pending,
  output logic [CNT_W-1:0]   fifo_count,
  output logic               overflow,
  input  logic               overflow_clr
);

  if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [NUM_BTN-1:0] pending_q;
  logic [NUM_BTN-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               overflow_q;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               push_ok;
  logic               lost;

  assign evt_valid = ~fifo_empty;
  assign pop       = evt_valid & evt_ready;
  assign push_ok   = ~fifo_full | pop;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    // Descending scan: the last hit is the lowest set index, i.e. highest priority.
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        grant_id = ID_W'(i);
      end
    end
    if (!push_ok) grant = '0;
  end

  // A repeat press on a bit that stays pending merges into it and is lost.
  assign lost = |(btn_pulse & pending_q & ~grant);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q <= (pending_q & ~grant) | btn_pulse;
      if (lost)              overflow_q <= 1'b1;
      else if (overflow_clr) overflow_q <= 1'b0;
    end
  end

  event_fifo #(
    .WIDTH (ID_W),
    .DEPTH (FIFO_DEPTH)
  ) u_event_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (|grant),
    .din   (grant_id),
    .pop   (pop),
    .head  (evt_id),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a queue-based behavioural model.
module tb_button_event_scheduler;
  import piano_pkg::*;

  localparam int NB    = 5;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn_pulse = '0;
  logic       evt_valid;
  logic [2:0] evt_id;
  logic       evt_ready = 1'b0;
  logic [4:0] pending;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       overflow_clr = 1'b0;

  button_event_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_pulse    (btn_pulse),
    .evt_valid    (evt_valid),
    .evt_id       (evt_id),
    .evt_ready    (evt_ready),
    .pending      (pending),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    else            n_pass++;
  endtask

  // Behavioural model: a queue of ids, a set of pending buttons, a sticky flag.
  int       mq[$];
  bit [4:0] mpend;
  bit       mov;
  bit       chk_en = 1'b0;

  always @(posedge clk) begin : model
    bit do_pop;
    bit lost;
    int g;
    if (!rst_n) begin
      mq.delete();
      mpend = '0;
      mov   = 1'b0;
    end else begin
      do_pop = (mq.size() != 0) && evt_ready;
      g = -1;
      if (mq.size() < DEPTH || do_pop)
        for (int b = 0; b < NB; b++) if (mpend[b] && g < 0) g = b;
      lost = 1'b0;
      for (int b = 0; b < NB; b++) if (btn_pulse[b] && mpend[b] && b != g) lost = 1'b1;
      if (do_pop) void'(mq.pop_front());
      if (g >= 0) begin
        mq.push_back(g);
        mpend[g] = 1'b0;
      end
      mpend = mpend | btn_pulse;
      if (lost)              mov = 1'b1;
      else if (overflow_clr) mov = 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      check("m_valid",    evt_valid,  int'(mq.size() != 0));
      check("m_count",    fifo_count, mq.size());
      check("m_pending",  pending,    mpend);
      check("m_overflow", overflow,   mov);
      if (mq.size() != 0) check("m_id", evt_id, mq[0]);
    end
  end

  // Ids accepted by the consumer, captured before the edge that pops them.
  int acc[$];

  // Called at a negedge; drives inputs for one cycle and returns at the next negedge.
  task automatic step(input logic [4:0] p, input logic r, input logic c);
    btn_pulse    = p;
    evt_ready    = r;
    overflow_clr = c;
    if (rst_n && evt_valid && r) acc.push_back(evt_id);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step('0, 1'b0, 1'b0);
    rst_n = 1'b1;
    acc.delete();
  endtask

  initial begin
    // Reset with pulses present: they must be ignored.
    rst_n     = 1'b0;
    btn_pulse = 5'b11111;
    @(negedge clk);
    @(negedge clk);
    btn_pulse = '0;
    rst_n     = 1'b1;
    check("rst_valid",    evt_valid,  0);
    check("rst_id",       evt_id,     0);
    check("rst_count",    fifo_count, 0);
    check("rst_pending",  pending,    0);
    check("rst_overflow", overflow,   0);
    chk_en = 1'b1;

    // Single press on L: pending next cycle, valid two cycles after the pulse.
    step(5'b1 << BTN_L, 1'b1, 1'b0);
    check("single_pending", pending, 5'b00100);
    check("single_early",   evt_valid, 0);
    step('0, 1'b1, 1'b0);
    check("single_valid", evt_valid, 1);
    check("single_id",    evt_id,    BTN_L);
    step('0, 1'b1, 1'b0);
    check("single_gone",  evt_valid,  0);
    check("single_count", fifo_count, 0);

    // Simultaneous C, U, D: emitted 0, 1, 4 on consecutive cycles.
    do_reset();
    step(5'b10011, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    check("sim_id0", evt_id, BTN_C);
    step('0, 1'b1, 1'b0);
    check("sim_id1", evt_id, BTN_U);
    step('0, 1'b1, 1'b0);
    check("sim_id4",   evt_id,  BTN_D);
    check("sim_pend0", pending, 0);
    step('0, 1'b1, 1'b0);
    check("sim_order_n", acc.size(), 3);
    if (acc.size() == 3) begin
      check("sim_acc0", acc[0], 0);
      check("sim_acc1", acc[1], 1);
      check("sim_acc2", acc[2], 4);
    end

    // Backpressure until full, then a lost press with clear in the same cycle.
    do_reset();
    for (int i = 0; i < NB; i++) step(5'b1 << i, 1'b0, 1'b0);
    check("full_count",   fifo_count, 4);
    check("full_pending", pending,    5'b10000);
    step(5'b1 << BTN_D, 1'b0, 1'b1);
    check("ovf_set_wins", overflow, 1);
    step('0, 1'b0, 1'b1);
    check("ovf_cleared", overflow, 0);
    repeat (8) step('0, 1'b1, 1'b0);
    check("drain_n", acc.size(), 5);
    for (int i = 0; i < acc.size() && i < 5; i++) check("drain_id", acc[i], i);

    // Stall: head id 3 held with evt_ready low.
    do_reset();
    step(5'b1 << BTN_R, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step('0, 1'b0, 1'b0);
      check("stall_id",    evt_id,     3);
      check("stall_count", fifo_count, 1);
    end
    step('0, 1'b1, 1'b0);

    // Reset mid-operation with three queued and two pending.
    do_reset();
    step(5'b11111, 1'b0, 1'b0);
    repeat (3) step('0, 1'b0, 1'b0);
    check("mid_count",   fifo_count, 3);
    check("mid_pending", pending,    5'b11000);
    rst_n = 1'b0;
    step('0, 1'b1, 1'b0);
    rst_n = 1'b1;
    check("mid_rst_valid",   evt_valid,  0);
    check("mid_rst_count",   fifo_count, 0);
    check("mid_rst_pending", pending,    0);
    check("mid_rst_id",      evt_id,     0);
    repeat (5) begin
      step('0, 1'b1, 1'b0);
      check("mid_quiet", evt_valid, 0);
    end
    step(5'b1 << BTN_U, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    check("mid_new_id", evt_id, BTN_U);

    // Randomized run; the compare process checks every cycle.
    for (int blk = 0; blk < 15; blk++) begin
      int rdy_pct;
      rdy_pct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 95);
      for (int c = 0; c < 200; c++) begin
        rst_n = ($urandom_range(0, 299) != 0);
        step(5'($urandom) & 5'($urandom),
             $urandom_range(0, 99) < rdy_pct,
             $urandom_range(0, 15) == 0);
      end
    end
    rst_n = 1'b1;
    step('0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
